// File: rtl/uop_sequencer.sv
// Instruction buffer and micro-op sequencer: queues fetched 16-bit instructions
// and issues one (or, for cracked STU/JAL/JALR, two) decoded uops per entry.
module uop_sequencer #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned CRACK_EN = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush_p1,
  input  logic                       inst_valid_p1,
  input  logic [15:0]                inst_p1,
  input  logic [DATA_W-1:0]          pc_p1,
  output logic                       inst_ready_p1,
  input  logic                       uop_ready_p1,
  output logic                       uop_valid_p1,
  output logic [4:0]                 uop_opcode_p1,
  output logic                       uop_seq_p1,
  output logic [2:0]                 uop_rs_p1,
  output logic [2:0]                 uop_rt_p1,
  output logic [2:0]                 uop_dest_p1,
  output logic [DATA_W-1:0]          uop_imm_p1,
  output logic [DATA_W-1:0]          uop_pc_p1,
  output logic                       uop_reg_write_p1,
  output logic                       uop_mem_store_p1,
  output logic                       uop_mem_load_p1,
  output logic                       uop_link_p1,
  output logic                       uop_jump_p1,
  output logic                       uop_illegal_p1,
  output logic                       uop_rti_p1,
  output logic                       halted_p1,
  output logic [$clog2(DEPTH+1)-1:0] buf_count_p1
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {S_ISSUE0, S_ISSUE1, S_HALTED} state_e;

  state_e            state_q, state_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [15:0]       inst_mem [DEPTH];
  logic [DATA_W-1:0] pc_mem   [DEPTH];

  logic [15:0] head_inst;
  logic [4:0]  op;
  logic        empty, push, pop;
  logic        is_nop, is_halt, cracked;

  assign head_inst     = inst_mem[rd_ptr_q];
  assign op            = head_inst[15:11];
  assign empty         = (count_q == '0);
  assign inst_ready_p1 = (count_q != CNT_W'(DEPTH));
  assign push          = inst_valid_p1 && inst_ready_p1 && !flush_p1;
  assign is_nop        = (op == 5'b00001);
  assign is_halt       = (op == 5'b00000);
  assign cracked       = (CRACK_EN != 0) &&
                         ((op == 5'b10011) || (op == 5'b00110) || (op == 5'b00111));

  assign buf_count_p1  = count_q;
  assign halted_p1     = (state_q == S_HALTED);
  assign uop_valid_p1  = (state_q == S_ISSUE1) ||
                         ((state_q == S_ISSUE0) && !empty && !is_nop);
  assign uop_seq_p1    = (state_q == S_ISSUE1);
  assign uop_opcode_p1 = op;
  assign uop_rs_p1     = head_inst[10:8];
  assign uop_rt_p1     = head_inst[7:5];
  assign uop_pc_p1     = pc_mem[rd_ptr_q];

  // Sequencer next state; flush wins over any pop and never leaves HALTED.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      S_ISSUE0: begin
        if (!empty) begin
          if (is_nop) begin
            pop = 1'b1;
          end else if (uop_ready_p1) begin
            if (cracked) begin
              state_d = S_ISSUE1;
            end else begin
              pop = 1'b1;
              if (is_halt) state_d = S_HALTED;
            end
          end
        end
      end
      S_ISSUE1: begin
        if (uop_ready_p1) begin
          pop     = 1'b1;
          state_d = S_ISSUE0;
        end
      end
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_ISSUE0;
    endcase
    if (flush_p1) begin
      pop = 1'b0;
      if (state_q != S_HALTED) state_d = S_ISSUE0;
    end
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_p1) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_ISSUE0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) begin
      inst_mem[wr_ptr_q] <= inst_p1;
      pc_mem[wr_ptr_q]   <= pc_p1;
    end
  end

  // Head decode; second uop of a cracked pair selected by uop_seq_p1.
  always_comb begin
    uop_imm_p1       = '0;
    uop_dest_p1      = 3'd0;
    uop_reg_write_p1 = 1'b0;
    uop_mem_store_p1 = 1'b0;
    uop_mem_load_p1  = 1'b0;
    uop_link_p1      = 1'b0;
    uop_jump_p1      = 1'b0;
    uop_illegal_p1   = 1'b0;
    uop_rti_p1       = 1'b0;
    casez (op)
      5'b00010: uop_illegal_p1 = 1'b1;
      5'b00011: uop_rti_p1     = 1'b1;
      5'b00100: begin
        uop_jump_p1 = 1'b1;
        uop_imm_p1  = {{(DATA_W-11){head_inst[10]}}, head_inst[10:0]};
      end
      5'b00101: begin
        uop_jump_p1 = 1'b1;
        uop_imm_p1  = {{(DATA_W-8){head_inst[7]}}, head_inst[7:0]};
      end
      5'b0011?: begin
        uop_imm_p1 = op[0] ? {{(DATA_W-8){head_inst[7]}}, head_inst[7:0]}
                           : {{(DATA_W-11){head_inst[10]}}, head_inst[10:0]};
        if (!cracked || !uop_seq_p1) begin
          uop_link_p1      = 1'b1;
          uop_reg_write_p1 = 1'b1;
          uop_dest_p1      = 3'd7;
        end
        if (!cracked || uop_seq_p1) uop_jump_p1 = 1'b1;
      end
      5'b0100?, 5'b101??: begin
        uop_imm_p1       = {{(DATA_W-5){head_inst[4]}}, head_inst[4:0]};
        uop_dest_p1      = head_inst[7:5];
        uop_reg_write_p1 = 1'b1;
      end
      5'b0101?: begin
        uop_imm_p1       = {{(DATA_W-5){1'b0}}, head_inst[4:0]};
        uop_dest_p1      = head_inst[7:5];
        uop_reg_write_p1 = 1'b1;
      end
      5'b011??: uop_imm_p1 = {{(DATA_W-8){head_inst[7]}}, head_inst[7:0]};
      5'b10000: begin
        uop_imm_p1       = {{(DATA_W-5){head_inst[4]}}, head_inst[4:0]};
        uop_mem_store_p1 = 1'b1;
      end
      5'b10001: begin
        uop_imm_p1       = {{(DATA_W-5){head_inst[4]}}, head_inst[4:0]};
        uop_mem_load_p1  = 1'b1;
        uop_dest_p1      = head_inst[7:5];
        uop_reg_write_p1 = 1'b1;
      end
      5'b10010: begin
        uop_imm_p1       = {{(DATA_W-8){1'b0}}, head_inst[7:0]};
        uop_dest_p1      = head_inst[10:8];
        uop_reg_write_p1 = 1'b1;
      end
      5'b10011: begin
        uop_imm_p1 = {{(DATA_W-5){head_inst[4]}}, head_inst[4:0]};
        if (!cracked || !uop_seq_p1) uop_mem_store_p1 = 1'b1;
        if (!cracked || uop_seq_p1) begin
          uop_reg_write_p1 = 1'b1;
          uop_dest_p1      = head_inst[10:8];
        end
      end
      5'b11000: begin
        uop_imm_p1       = {{(DATA_W-8){head_inst[7]}}, head_inst[7:0]};
        uop_dest_p1      = head_inst[10:8];
        uop_reg_write_p1 = 1'b1;
      end
      5'b11001, 5'b1101?, 5'b111??: begin
        uop_dest_p1      = head_inst[4:2];
        uop_reg_write_p1 = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_uop_sequencer.sv
// Bench for uop_sequencer: directed scenarios plus randomized traffic checked
// against an instruction-queue model that expands each entry into its uops.
module tb_uop_sequencer;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1);

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              flush = 1'b0, inst_valid = 1'b0, uop_ready = 1'b0;
  logic [15:0]       inst = '0;
  logic [DATA_W-1:0] pc = '0;

  logic              inst_ready, uop_valid, uop_seq, halted;
  logic [4:0]        uop_opcode;
  logic [2:0]        uop_rs, uop_rt, uop_dest;
  logic [DATA_W-1:0] uop_imm, uop_pc;
  logic              f_rw, f_st, f_ld, f_link, f_jump, f_ill, f_rti;
  logic [CNT_W-1:0]  buf_count;

  logic              d1_inst_ready, d1_uop_valid, d1_uop_seq, d1_halted;
  logic [4:0]        d1_uop_opcode;
  logic [2:0]        d1_uop_rs, d1_uop_rt, d1_uop_dest;
  logic [DATA_W-1:0] d1_uop_imm, d1_uop_pc;
  logic              d1_rw, d1_st, d1_ld, d1_link, d1_jump, d1_ill, d1_rti;
  logic [CNT_W-1:0]  d1_buf_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uop_sequencer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CRACK_EN(1)) dut (
    .clk(clk), .rst(rst), .flush_p1(flush), .inst_valid_p1(inst_valid),
    .inst_p1(inst), .pc_p1(pc), .inst_ready_p1(inst_ready),
    .uop_ready_p1(uop_ready), .uop_valid_p1(uop_valid),
    .uop_opcode_p1(uop_opcode), .uop_seq_p1(uop_seq), .uop_rs_p1(uop_rs),
    .uop_rt_p1(uop_rt), .uop_dest_p1(uop_dest), .uop_imm_p1(uop_imm),
    .uop_pc_p1(uop_pc), .uop_reg_write_p1(f_rw), .uop_mem_store_p1(f_st),
    .uop_mem_load_p1(f_ld), .uop_link_p1(f_link), .uop_jump_p1(f_jump),
    .uop_illegal_p1(f_ill), .uop_rti_p1(f_rti), .halted_p1(halted),
    .buf_count_p1(buf_count)
  );

  uop_sequencer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CRACK_EN(0)) dut_nocrack (
    .clk(clk), .rst(rst), .flush_p1(flush), .inst_valid_p1(inst_valid),
    .inst_p1(inst), .pc_p1(pc), .inst_ready_p1(d1_inst_ready),
    .uop_ready_p1(uop_ready), .uop_valid_p1(d1_uop_valid),
    .uop_opcode_p1(d1_uop_opcode), .uop_seq_p1(d1_uop_seq), .uop_rs_p1(d1_uop_rs),
    .uop_rt_p1(d1_uop_rt), .uop_dest_p1(d1_uop_dest), .uop_imm_p1(d1_uop_imm),
    .uop_pc_p1(d1_uop_pc), .uop_reg_write_p1(d1_rw), .uop_mem_store_p1(d1_st),
    .uop_mem_load_p1(d1_ld), .uop_link_p1(d1_link), .uop_jump_p1(d1_jump),
    .uop_illegal_p1(d1_ill), .uop_rti_p1(d1_rti), .halted_p1(d1_halted),
    .buf_count_p1(d1_buf_count)
  );

  typedef struct packed {
    logic [4:0]  op;
    logic        seq;
    logic [2:0]  rs, rt, dest;
    logic [15:0] imm;
    logic [6:0]  flags;   // {reg_write, store, load, link, jump, illegal, rti}
  } exp_t;

  // Reference state: queued instructions, uops already issued from the head.
  logic [15:0] q_inst[$];
  logic [15:0] q_pc[$];
  int          m_part;
  bit          m_halted;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int n_uops(input logic [15:0] ins, input bit crack);
    logic [4:0] o;
    o = ins[15:11];
    if (crack && (o == 5'd19 || o == 5'd6 || o == 5'd7)) return 2;
    return 1;
  endfunction

  function automatic exp_t exp_uop(input logic [15:0] ins, input int idx, input bit crack);
    exp_t u;
    int o, grp;
    bit rw, st, ld, lk, jp, two;
    o   = int'(ins[15:11]);
    grp = o / 4;
    two = (n_uops(ins, crack) == 2);
    u = '0;
    u.op = ins[15:11]; u.seq = (idx == 1); u.rs = ins[10:8]; u.rt = ins[7:5];
    rw = 0; st = 0; ld = 0; lk = 0; jp = 0;
    if (o == 18)                                 u.imm = {8'h00, ins[7:0]};
    else if (o == 10 || o == 11)                 u.imm = {11'h000, ins[4:0]};
    else if (grp == 2 || grp == 4 || grp == 5)   u.imm = {{11{ins[4]}}, ins[4:0]};
    else if (o == 4 || o == 6)                   u.imm = {{5{ins[10]}}, ins[10:0]};
    else if (o == 5 || o == 7 || grp == 3 || o == 24) u.imm = {{8{ins[7]}}, ins[7:0]};
    if (grp == 2 || grp == 5 || o == 17) begin rw = 1; u.dest = ins[7:5]; end
    if (o == 25 || o >= 26)              begin rw = 1; u.dest = ins[4:2]; end
    if (o == 24 || o == 18)              begin rw = 1; u.dest = ins[10:8]; end
    if (o == 16) st = 1;
    if (o == 17) ld = 1;
    if (o == 4 || o == 5) jp = 1;
    if (o == 19) begin
      if (!two || idx == 0) st = 1;
      if (!two || idx == 1) begin rw = 1; u.dest = ins[10:8]; end
    end
    if (o == 6 || o == 7) begin
      if (!two || idx == 0) begin lk = 1; rw = 1; u.dest = 3'd7; end
      if (!two || idx == 1) jp = 1;
    end
    u.flags = {rw, st, ld, lk, jp, (o == 2), (o == 3)};
    return u;
  endfunction

  task automatic model_clear();
    q_inst.delete(); q_pc.delete(); m_part = 0; m_halted = 0;
  endtask

  task automatic model_step(input bit v, input logic [15:0] ins, input logic [15:0] p,
                            input bit rdy, input bit fl);
    int sz0;
    sz0 = q_inst.size();
    if (fl) begin
      q_inst.delete(); q_pc.delete(); m_part = 0;
      return;
    end
    if (!m_halted && sz0 > 0) begin
      if (q_inst[0][15:11] == 5'd1) begin
        void'(q_inst.pop_front()); void'(q_pc.pop_front());
      end else if (rdy) begin
        m_part++;
        if (m_part == n_uops(q_inst[0], 1'b1)) begin
          if (q_inst[0][15:11] == 5'd0) m_halted = 1;
          void'(q_inst.pop_front()); void'(q_pc.pop_front());
          m_part = 0;
        end
      end
    end
    if (v && sz0 != DEPTH) begin
      q_inst.push_back(ins); q_pc.push_back(p);
    end
  endtask

  task automatic compare_all();
    bit   ev;
    exp_t u;
    ev = !m_halted && q_inst.size() > 0 && q_inst[0][15:11] != 5'd1;
    check("inst_ready", 32'(inst_ready), 32'(q_inst.size() != DEPTH));
    check("buf_count", 32'(buf_count), 32'(q_inst.size()));
    check("halted", 32'(halted), 32'(m_halted));
    check("uop_valid", 32'(uop_valid), 32'(ev));
    if (ev) begin
      u = exp_uop(q_inst[0], m_part, 1'b1);
      check("opcode", 32'(uop_opcode), 32'(u.op));
      check("seq", 32'(uop_seq), 32'(u.seq));
      check("rs_rt", 32'({uop_rs, uop_rt}), 32'({u.rs, u.rt}));
      check("dest", 32'(uop_dest), 32'(u.dest));
      check("imm", 32'(uop_imm), 32'(u.imm));
      check("pc", 32'(uop_pc), 32'(q_pc[0]));
      check("flags", 32'({f_rw, f_st, f_ld, f_link, f_jump, f_ill, f_rti}), 32'(u.flags));
    end
  endtask

  // One clock: drive at negedge, model at posedge, compare at next negedge.
  task automatic step(input bit v, input logic [15:0] ins, input logic [15:0] p,
                      input bit rdy, input bit fl);
    inst_valid = v; inst = ins; pc = p; uop_ready = rdy; flush = fl;
    @(posedge clk);
    model_step(v, ins, p, rdy, fl);
    @(negedge clk);
    compare_all();
  endtask

  task automatic do_reset();
    inst_valid = 1'b0; uop_ready = 1'b0; flush = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_valid", 32'(uop_valid), 32'd0);
    check("rst_count", 32'(buf_count), 32'd0);
    check("rst_ready", 32'(inst_ready), 32'd1);
    model_clear();
    @(negedge clk);
    rst = 1'b1;
  endtask

  function automatic logic [15:0] rand_inst();
    logic [15:0] r;
    r = 16'($urandom);
    if (r[15:11] == 5'd0 && $urandom_range(0, 7) != 0) r[15:11] = 5'b01000;
    return r;
  endfunction

  initial begin
    @(negedge clk);
    do_reset();

    // ADDI single uop, buffer drains
    step(1, 16'h4125, 16'h0010, 1, 0);
    check("addi_valid", 32'(uop_valid), 32'd1);
    check("addi_op", 32'(uop_opcode), 32'h08);
    check("addi_dest", 32'(uop_dest), 32'd1);
    check("addi_imm", 32'(uop_imm), 32'h0005);
    check("addi_rw", 32'(f_rw), 32'd1);
    step(0, 16'h0, 16'h0, 1, 0);
    check("addi_count", 32'(buf_count), 32'd0);

    // STU cracked vs. single-uop union
    do_reset();
    step(1, 16'h9C3F, 16'h0020, 1, 0);
    check("stu0_store", 32'(f_st), 32'd1);
    check("stu0_imm", 32'(uop_imm), 32'hFFFF);
    check("stu0_seq", 32'(uop_seq), 32'd0);
    check("nc_valid", 32'(d1_uop_valid), 32'd1);
    check("nc_flags", 32'({d1_rw, d1_st, d1_ld, d1_link, d1_jump, d1_ill, d1_rti}), 32'h60);
    check("nc_dest_seq", 32'({d1_uop_dest, d1_uop_seq}), 32'({3'd4, 1'b0}));
    step(0, 16'h0, 16'h0, 1, 0);
    check("stu1_seq", 32'(uop_seq), 32'd1);
    check("stu1_rw_st", 32'({f_rw, f_st}), 32'b10);
    check("stu1_dest", 32'(uop_dest), 32'd4);
    check("nc_done", 32'(d1_uop_valid), 32'd0);
    step(0, 16'h0, 16'h0, 1, 0);

    // Fill to full with execute stalled, then release in order
    do_reset();
    for (int i = 0; i < 5; i++) step(1, 16'h4120 | 16'(i), 16'h0100 + 16'(2 * i), 0, 0);
    check("full_ready", 32'(inst_ready), 32'd0);
    check("full_count", 32'(buf_count), 32'd4);
    step(1, 16'h4124, 16'h0108, 1, 0);
    for (int i = 0; i < 6; i++) step(0, 16'h0, 16'h0, 1, 0);
    check("drain_count", 32'(buf_count), 32'd0);

    // Flush while JAL is half issued
    do_reset();
    step(1, 16'h3000, 16'h0040, 0, 0);
    step(0, 16'h0, 16'h0, 1, 0);
    check("jal1_seq", 32'(uop_seq), 32'd1);
    step(0, 16'h0, 16'h0, 0, 0);
    step(1, 16'h4125, 16'h0050, 0, 1);
    check("flush_count", 32'(buf_count), 32'd0);
    check("flush_valid", 32'(uop_valid), 32'd0);
    step(0, 16'h0, 16'h0, 1, 0);

    // HALT is sticky until reset
    do_reset();
    step(1, 16'h0000, 16'h0060, 1, 0);
    step(1, 16'hD804, 16'h0062, 1, 0);
    check("halt_flag", 32'(halted), 32'd1);
    check("halt_valid", 32'(uop_valid), 32'd0);
    step(0, 16'h0, 16'h0, 1, 1);
    check("halt_flush", 32'(halted), 32'd1);
    do_reset();

    // Randomized traffic, reset between segments
    for (int seg = 0; seg < 8; seg++) begin
      for (int c = 0; c < 300; c++)
        step($urandom_range(0, 3) != 0, rand_inst(), 16'($urandom),
             $urandom_range(0, 9) < 7, $urandom_range(0, 39) == 0);
      do_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
